// File: rtl/inv_shift_rows_stage.sv
// Registered InvShiftRows stage for the 64-bit AES decryption datapath.
// Each accepted beat is optionally XORed with the round key, byte-permuted
// by InvShiftRows (4 rows x 2 columns, column-major), and written into a
// 2-entry FIFO together with its round tag.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. valid, once raised, is expected to hold its payload
// until the transfer; ready may change freely. in_ready depends only on
// rst_n and the registered occupancy, never combinationally on out_ready.
module inv_shift_rows_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_xor_en,
  input  logic [63:0]      round_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occ,
  output logic [15:0]      blk_cnt
);

  // Byte k lives at x[63-8k -: 8]; rows 1 and 3 swap columns, rows 0 and 2 stay.
  function automatic logic [63:0] inv_shift_rows(input logic [63:0] x);
    logic [63:0] y;
    y[63:56] = x[63:56]; // out0 <- x0
    y[55:48] = x[23:16]; // out1 <- x5
    y[47:40] = x[47:40]; // out2 <- x2
    y[39:32] = x[7:0];   // out3 <- x7
    y[31:24] = x[31:24]; // out4 <- x4
    y[23:16] = x[55:48]; // out5 <- x1
    y[15:8]  = x[15:8];  // out6 <- x6
    y[7:0]   = x[39:32]; // out7 <- x3
    return y;
  endfunction

  logic [63:0]      data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;

  logic             push, pop;
  logic [63:0]      xored;
  logic [63:0]      permuted;

  assign in_ready  = rst_n & (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign xored     = in_xor_en ? (in_data ^ round_key) : in_data;
  assign permuted  = inv_shift_rows(xored);

  // Head entry is presented only while the FIFO holds something; empty reads 0.
  assign out_data  = out_valid ? data_q[rd_ptr_q] : 64'd0;
  assign out_tag   = out_valid ? tag_q[rd_ptr_q]  : '0;
  assign occ       = occ_q;
  assign blk_cnt   = blk_cnt_q;

  // Next-state for pointers, occupancy and the delivered-beat counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    blk_cnt_d = blk_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control registers; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      blk_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // Storage: the transformed beat is written at the push edge, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= 64'd0;
        tag_q[i]  <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= permuted;
      tag_q[wr_ptr_q]  <= in_tag;
    end
  end

endmodule
